inj_src_feeder: RTL
===================

Name: inj_src_feeder

Overview:
- Host-side feeder that sits directly upstream of the many-core's injector source ports (MA or App injector src_rx/src_credit/src_data).
- Accepts 32-bit words from a host or testbench over a valid/ready stream, buffers them in a first-word-fall-through FIFO, and drives the credit-based injector source interface.
- A framer tracks Hermes packet boundaries (header, size, payload) for status and error reporting. It never alters data.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit words; power of two, minimum 2.
- MAX_PAYLOAD_SIZE, 32, largest legal size-flit value; larger values raise size_err_o.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk_i  input  1  clock; all state is on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- host_valid_i  input  1  host word valid.
- host_ready_o  output  1  feeder can accept a host word.
- host_data_i  input  32  host word.
- src_rx_o  output  1  flit valid toward injector src_rx_i.
- src_credit_i  input  1  injector can accept a flit (from injector src_credit_o).
- src_data_o  output  32  flit toward injector src_data_i.
- busy_o  output  1  framer is mid-packet (state not HDR) or FIFO is not empty.
- pkt_count_o  output  CNT_W  number of completed packets sent; wraps.
- size_err_o  output  1  sticky; set when a size flit exceeds MAX_PAYLOAD_SIZE.
- level_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_i high, asynchronous):
  - FIFO is emptied, so level_o=0, src_rx_o=0 and src_data_o=0.
  - host_ready_o=0 while rst_i is high, and 1 from the first cycle after release.
  - Framer returns to HDR; pkt_count_o=0; size_err_o=0; busy_o=0.
  - A reset mid-packet discards any partial packet with no other effect.
- Push:
  - host_ready_o = !full and is registered-independent of host_valid_i.
  - A push occurs when host_valid_i && host_ready_o.
- Pop:
  - src_rx_o = !empty; src_data_o = FIFO head, or 0 when empty.
  - A pop occurs when src_rx_o && src_credit_i.
  - Pop latency is 0: a word pushed in cycle N is visible on src_rx_o in cycle N+1.
- Simultaneous push and pop:
  - Level is unchanged; both take effect.
  - When full, host_ready_o=0, so no push occurs even if a pop happens in the same cycle.
  - When empty, a push and pop cannot coincide because src_rx_o=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Level is tracked separately, so full means level==DEPTH.
- src_data_o must stay stable while src_rx_o=1 and src_credit_i=0.
- Framer FSM advances only on pop:
  - HDR: pop -> SIZE.
  - SIZE: pop latches remaining = popped word.
    - If the word is 0: pkt_count++ and go to HDR.
    - Otherwise go to PAYLOAD.
    - If the word > MAX_PAYLOAD_SIZE: size_err_o is set (sticky until reset) and the flits still pass through unchanged.
  - PAYLOAD: each pop decrements remaining. A pop with remaining==1 does pkt_count++ and goes to HDR.
- pkt_count_o updates in the cycle after the final flit's pop and wraps from 2^CNT_W-1 to 0.
- The remaining counter is 32 bits and cannot underflow, because the exit condition is at 1.
- A stalled credit (src_credit_i low indefinitely) holds all framer state; no timeout applies.

Test Plan:
- Reset check: hold rst_i high for 3 cycles with host_valid_i=1 -> host_ready_o=0, src_rx_o=0, level_o=0, pkt_count_o=0 throughout.
- Single packet: push {0x00000102, 3, 0xA, 0xB, 0xC} with src_credit_i always 1 -> src_data_o presents the same five words in order, each one cycle after its push; pkt_count_o=1 after the 5th pop; busy_o returns to 0.
- Backpressure and full (DEPTH=8):
  - Hold src_credit_i=0 and push 10 words -> host_ready_o drops after the 8th word, level_o=8, src_data_o holds word 0.
  - Release credit -> all 10 words delivered in order with no loss or duplication.
  - Repeat with DEPTH=8 so the pointers wrap.
- Zero-size and oversize packets:
  - Header, then size 0 -> pkt_count increments after 2 flits.
  - Header, then size 40 with 40 payload words -> size_err_o=1, all 42 flits forwarded, pkt_count increments once.
- Simultaneous push/pop: random 50% credit toggling with continuous valid over 200 words -> level_o never exceeds DEPTH, a scoreboard sees the output equal to the input, and level_o stays constant in cycles with both a push and a pop.
- Mid-packet reset: assert rst_i after the 2nd payload flit of a size-5 packet, then send a fresh 3-flit packet (size 1) -> the FIFO restarts empty, the new packet frames correctly, and pkt_count_o=1.

Source files
------------

// File: rtl/inj_src_feeder.sv
// -----------------------------------------------------------------------------
// inj_src_feeder
//
// Host-side feeder placed directly upstream of a many-core injector source
// port. Host words arrive over a valid/ready stream, are buffered in a
// first-word-fall-through FIFO, and leave on the credit-based injector source
// interface (src_rx / src_credit / src_data). A passive framer follows the
// Hermes packet structure (header, size, payload) only for status and error
// reporting. It never modifies or stalls data.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   host_valid_i   host word valid
//   host_ready_o   feeder can accept a host word (FIFO not full)
//   host_data_i    host word
//   src_rx_o       flit valid toward injector (FIFO not empty)
//   src_credit_i   injector accepts the presented flit
//   src_data_o     flit toward injector (FIFO head, 0 when empty)
//   busy_o         framer mid-packet or FIFO not empty
//   pkt_count_o    completed packets sent, wraps
//   size_err_o     sticky: a size flit exceeded MAX_PAYLOAD_SIZE
//   level_o        FIFO occupancy
//
// Framer states
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_HDR     | next popped flit is a packet header
//   ST_SIZE    | next popped flit is the payload size
//   ST_PAYLOAD | remaining_q payload flits still to be popped
// -----------------------------------------------------------------------------
module inj_src_feeder #(
    parameter int DEPTH            = 8,   // power of two, >= 2
    parameter int MAX_PAYLOAD_SIZE = 32,
    parameter int CNT_W            = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   host_valid_i,
    output logic                   host_ready_o,
    input  logic [31:0]            host_data_i,
    output logic                   src_rx_o,
    input  logic                   src_credit_i,
    output logic [31:0]            src_data_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       pkt_count_o,
    output logic                   size_err_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               LVL_W    = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [31:0]      MAX_SIZE = 32'(MAX_PAYLOAD_SIZE);

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_en_q;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Framer state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             size_err_q, size_err_d;
    logic             pkt_done;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);

    // ready_en_q holds ready low for the whole reset and releases it on the
    // first clock after reset deassertion, so no push can race the reset.
    assign host_ready_o = ready_en_q && !full;
    assign src_rx_o     = !empty;
    // Head is only written by a push while the FIFO is empty, so it cannot
    // change while a flit is presented and waiting for credit.
    assign src_data_o   = empty ? 32'd0 : mem_q[rd_ptr_q];

    assign push = host_valid_i && host_ready_o;
    assign pop  = src_rx_o && src_credit_i;

    assign level_o     = level_q;
    assign pkt_count_o = pkt_count_q;
    assign size_err_o  = size_err_q;
    assign busy_o      = (state_q != ST_HDR) || !empty;

    // ------------------------------------------------------------------
    // FIFO next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; stale contents are masked by the empty check.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_en_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Framer: advances only on pop, observes the popped flit
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        size_err_d  = size_err_q;
        pkt_done    = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (pop) begin
                    state_d = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (pop) begin
                    remaining_d = src_data_o;
                    if (src_data_o > MAX_SIZE) begin
                        size_err_d = 1'b1;
                    end
                    if (src_data_o == 32'd0) begin
                        pkt_done = 1'b1;
                        state_d  = ST_HDR;
                    end else begin
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // Exit at 1 so remaining_q never decrements through zero.
                if (pop) begin
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        pkt_done = 1'b1;
                        state_d  = ST_HDR;
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        pkt_count_d = pkt_count_q;
        if (pkt_done) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            pkt_count_q <= '0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pkt_count_q <= pkt_count_d;
            size_err_q  <= size_err_d;
        end
    end

endmodule
